// File: rtl/ps2_key_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ps2_key_serializer                                               |
// | Brief   : Turns hps_io ps2_key events into set-2 PS/2 frames on clk/data.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ps2_key_serializer #(
    parameter int HALF_CLKS  = 1145,
    parameter int GAP_CLKS   = 2864,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    output logic        ps2_clk,
    output logic        ps2_data,
    output logic        busy,
    output logic        overflow
);
    localparam int c_cnt_max = (HALF_CLKS > GAP_CLKS) ? HALF_CLKS : GAP_CLKS;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(HALF_CLKS - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_CLKS - 1);
    localparam logic [c_lvl_w-1:0] c_depth     = c_lvl_w'(FIFO_DEPTH);
    localparam logic [3:0]         c_stop_idx  = 4'd10;

    typedef enum logic [1:0] {EQ_IDLE, EQ_E0, EQ_F0, EQ_CODE} eq_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_BIT, TX_GAP}         tx_state_t;

    eq_state_t            r_eq_state, w_eq_next;
    tx_state_t            r_tx_state, w_tx_next;
    logic                 r_armed, r_tog_q, r_rel, r_overflow;
    logic [7:0]           r_code;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_lvl_w-1:0]   r_count;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_next;
    logic                 r_phase_hi, w_phase_next;
    logic [3:0]           r_bit_idx, w_idx_next;
    logic [10:0]          r_shift, w_shift_next;
    logic                 r_ps2_clk, r_ps2_data;

    logic                 w_event, w_accept, w_push, w_pop;
    logic [1:0]           w_needed;
    logic [c_lvl_w-1:0]   w_free;
    logic [7:0]           w_push_data, w_head;

    // Admission is all-or-nothing so a dropped event never leaves a stray prefix.
    assign w_event  = r_armed & (ps2_key[10] != r_tog_q);
    assign w_needed = 2'd1 + {1'b0, ps2_key[8]} + {1'b0, ~ps2_key[9]};
    assign w_free   = c_depth - r_count;
    assign w_accept = w_event & (r_eq_state == EQ_IDLE) & (w_free >= c_lvl_w'(w_needed));
    assign w_head   = r_mem[r_rd_ptr];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_armed    <= 1'b0;
            r_tog_q    <= 1'b0;
            r_rel      <= 1'b0;
            r_code     <= '0;
            r_overflow <= 1'b0;
            r_eq_state <= EQ_IDLE;
        end else begin
            r_armed    <= 1'b1;
            r_tog_q    <= ps2_key[10];
            r_overflow <= w_event & ~w_accept;
            r_eq_state <= w_eq_next;
            if (w_accept) begin
                r_rel  <= ~ps2_key[9];
                r_code <= ps2_key[7:0];
            end
        end
    end

    always_comb begin
        w_eq_next   = r_eq_state;
        w_push      = 1'b0;
        w_push_data = r_code;
        case (r_eq_state)
            EQ_IDLE: begin
                if (w_accept)
                    w_eq_next = ps2_key[8] ? EQ_E0 : (~ps2_key[9] ? EQ_F0 : EQ_CODE);
            end
            EQ_E0: begin
                w_push      = 1'b1;
                w_push_data = 8'hE0;
                w_eq_next   = r_rel ? EQ_F0 : EQ_CODE;
            end
            EQ_F0: begin
                w_push      = 1'b1;
                w_push_data = 8'hF0;
                w_eq_next   = EQ_CODE;
            end
            default: begin
                w_push    = 1'b1;
                w_eq_next = EQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_push_data;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_lvl_w'(1);
                2'b01:   r_count <= r_count - c_lvl_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Shift register holds {stop, parity, data, start}; bit 0 is on the wire.
    always_comb begin
        w_tx_next    = r_tx_state;
        w_cnt_next   = r_cnt;
        w_phase_next = r_phase_hi;
        w_idx_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_shift_next = {1'b1, ~^w_head, w_head, 1'b0};
                    w_tx_next    = TX_BIT;
                    w_cnt_next   = '0;
                    w_phase_next = 1'b1;
                    w_idx_next   = '0;
                end
            end
            TX_BIT: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_next = '0;
                    if (r_phase_hi) begin
                        w_phase_next = 1'b0;
                    end else if (r_bit_idx == c_stop_idx) begin
                        w_tx_next = TX_GAP;
                    end else begin
                        w_phase_next = 1'b1;
                        w_idx_next   = r_bit_idx + 4'd1;
                        w_shift_next = {1'b1, r_shift[10:1]};
                    end
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            TX_GAP: begin
                if (r_cnt == c_gap_last) begin
                    w_cnt_next = '0;
                    w_tx_next  = TX_IDLE;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_w'(1);
                end
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state <= TX_IDLE;
            r_cnt      <= '0;
            r_phase_hi <= 1'b1;
            r_bit_idx  <= '0;
            r_shift    <= '1;
            r_ps2_clk  <= 1'b1;
            r_ps2_data <= 1'b1;
        end else begin
            r_tx_state <= w_tx_next;
            r_cnt      <= w_cnt_next;
            r_phase_hi <= w_phase_next;
            r_bit_idx  <= w_idx_next;
            r_shift    <= w_shift_next;
            r_ps2_clk  <= (w_tx_next != TX_BIT) | w_phase_next;
            r_ps2_data <= (w_tx_next != TX_BIT) | w_shift_next[0];
        end
    end

    assign ps2_clk  = r_ps2_clk;
    assign ps2_data = r_ps2_data;
    assign overflow = r_overflow;
    assign busy     = (r_count != '0) | (r_tx_state != TX_IDLE) | (r_eq_state != EQ_IDLE);

endmodule
`default_nettype wire
